// File: rtl/modulo_debounce_botao.sv
// Push-button debouncer: synchronises a bouncing button and the divider tick into clk,
// then accepts a new level only after STABLE_COUNT consecutive equal samples.
module modulo_debounce_botao #(
   parameter int unsigned STABLE_COUNT = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic clk_div,
   input  logic btn,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   // Bit 1 of the encoding is the debounced level of each state.
   localparam logic [1:0] IDLE_LOW   = 2'd0;
   localparam logic [1:0] CHECK_HIGH = 2'd1;
   localparam logic [1:0] IDLE_HIGH  = 2'd2;
   localparam logic [1:0] CHECK_LOW  = 2'd3;

   localparam logic [3:0] CNT_LAST = 4'(STABLE_COUNT - 1);

   logic       clk_div_m_q, clk_div_s_q, clk_div_p_q;
   logic       btn_m_q, btn_s_q;
   logic       sample_tick;
   logic [1:0] state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       level_q, level_d;
   logic       press_q, press_d;
   logic       release_q, release_d;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         clk_div_m_q <= 1'b0;
         clk_div_s_q <= 1'b0;
         clk_div_p_q <= 1'b0;
         btn_m_q     <= 1'b0;
         btn_s_q     <= 1'b0;
      end else begin
         clk_div_m_q <= clk_div;
         clk_div_s_q <= clk_div_m_q;
         clk_div_p_q <= clk_div_s_q;
         btn_m_q     <= btn;
         btn_s_q     <= btn_m_q;
      end
   end

   assign sample_tick = clk_div_s_q & ~clk_div_p_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE_LOW: begin
            if (sample_tick && btn_s_q) begin
               state_d = CHECK_HIGH;
               cnt_d   = 4'd1;
            end else begin
               cnt_d = 4'd0;
            end
         end
         CHECK_HIGH: begin
            if (sample_tick) begin
               if (!btn_s_q) begin
                  state_d = IDLE_LOW;
                  cnt_d   = 4'd0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = IDLE_HIGH;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         IDLE_HIGH: begin
            if (sample_tick && !btn_s_q) begin
               state_d = CHECK_LOW;
               cnt_d   = 4'd1;
            end else begin
               cnt_d = 4'd0;
            end
         end
         CHECK_LOW: begin
            if (sample_tick) begin
               if (btn_s_q) begin
                  state_d = IDLE_HIGH;
                  cnt_d   = 4'd0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = IDLE_LOW;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
      endcase
   end

   always_comb begin
      level_d   = state_d[1];
      press_d   = (state_q == CHECK_HIGH) && (state_d == IDLE_HIGH);
      release_d = (state_q == CHECK_LOW) && (state_d == IDLE_LOW);
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q   <= IDLE_LOW;
         cnt_q     <= 4'd0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule

// File: tb/tb_modulo_debounce_botao.sv
// Directed bench for modulo_debounce_botao: clean press/release, bounce, glitch,
// asynchronous reset mid-check and a stalled divider.
module tb_modulo_debounce_botao;

   logic clk;
   logic clr;
   logic clk_div;
   logic btn;
   logic btn_level;
   logic btn_press;
   logic btn_release;

   int n_checks = 0;
   int n_errors = 0;
   int n_press = 0;
   int n_release = 0;
   int n_both = 0;
   int base_p;
   int base_r;

   modulo_debounce_botao #(
      .STABLE_COUNT(4)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .clk_div    (clk_div),
      .btn        (btn),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counts are cycle counts, so a stretched pulse shows up as 2.
   always @(negedge clk) begin
      if (btn_press) n_press++;
      if (btn_release) n_release++;
      if (btn_press && btn_release) n_both++;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One full divider period (8 clk high, 8 clk low) with btn set at its start.
   task automatic sample(input logic b);
      btn     = b;
      clk_div = 1'b1;
      repeat (8) @(negedge clk);
      clk_div = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic snap();
      base_p = n_press;
      base_r = n_release;
   endtask

   initial begin
      clr     = 1'b1;
      clk_div = 1'b0;
      btn     = 1'b0;
      #2 clr = 1'b0;
      #1;
      check_eq("reset_level", int'(btn_level), 0);
      check_eq("reset_press", int'(btn_press), 0);
      check_eq("reset_release", int'(btn_release), 0);
      repeat (3) @(negedge clk);
      clr = 1'b1;
      repeat (2) @(negedge clk);

      // Clean press
      snap();
      repeat (3) sample(1'b1);
      check_eq("press_level_after3", int'(btn_level), 0);
      sample(1'b1);
      check_eq("press_level_after4", int'(btn_level), 1);
      check_eq("press_pulses", n_press - base_p, 1);
      check_eq("press_no_release", n_release - base_r, 0);

      // Clean release
      snap();
      repeat (3) sample(1'b0);
      check_eq("release_level_after3", int'(btn_level), 1);
      sample(1'b0);
      check_eq("release_level_after4", int'(btn_level), 0);
      check_eq("release_pulses", n_release - base_r, 1);
      check_eq("release_no_press", n_press - base_p, 0);

      // Bounce 1,0,1 then steady 1: needs 4 consecutive highs from the last rise
      snap();
      sample(1'b1);
      sample(1'b0);
      sample(1'b1);
      sample(1'b1);
      sample(1'b1);
      check_eq("bounce_level_pending", int'(btn_level), 0);
      check_eq("bounce_no_press_yet", n_press - base_p, 0);
      sample(1'b1);
      check_eq("bounce_level", int'(btn_level), 1);
      check_eq("bounce_pulses", n_press - base_p, 1);
      repeat (4) sample(1'b0);
      check_eq("bounce_back_low", int'(btn_level), 0);

      // Glitch between ticks never reaches a sample
      snap();
      btn = 1'b1;
      repeat (3) @(negedge clk);
      btn = 1'b0;
      repeat (10) @(negedge clk);
      repeat (2) sample(1'b0);
      check_eq("glitch_level", int'(btn_level), 0);
      check_eq("glitch_no_press", n_press - base_p, 0);

      // Asynchronous reset while level is high, between clock edges
      repeat (4) sample(1'b1);
      check_eq("async_pre_level", int'(btn_level), 1);
      #2 clr = 1'b0;
      #1;
      check_eq("async_level_cleared", int'(btn_level), 0);
      @(negedge clk);
      clr = 1'b1;

      // Reset mid-check: two highs, reset, then four fresh highs
      snap();
      repeat (2) sample(1'b1);
      clr = 1'b0;
      #1;
      check_eq("midchk_level_in_reset", int'(btn_level), 0);
      @(negedge clk);
      clr = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("midchk_no_pulse_after_clr", n_press - base_p, 0);
      repeat (3) sample(1'b1);
      check_eq("midchk_level_after3", int'(btn_level), 0);
      sample(1'b1);
      check_eq("midchk_level_after4", int'(btn_level), 1);
      check_eq("midchk_pulses", n_press - base_p, 1);

      // Divider stalled: btn activity must not move anything
      snap();
      clk_div = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         btn = ($urandom_range(0, 1) != 0);
         @(negedge clk);
      end
      btn = 1'b1;
      check_eq("stall_level", int'(btn_level), 1);
      check_eq("stall_no_press", n_press - base_p, 0);
      check_eq("stall_no_release", n_release - base_r, 0);

      check_eq("never_both_pulses", n_both, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/modulo_debounce_botao.md
MODULO_DEBOUNCE_BOTAO -- requirements
Module: modulo_debounce_botao

Interface
REQ-001 SHALL have parameter STABLE_COUNT, default 4, giving the number of consecutive equal samples needed to accept a new button level; legal range 2..15.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port clr, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port clk_div, input, 1 bit: slow sampling signal driven by the frequency divider output, asynchronous to clk.
REQ-005 SHALL have port btn, input, 1 bit: raw mechanical button level, active-high, asynchronous and bouncing.
REQ-006 SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-007 SHALL have port btn_press, output, 1 bit: single-clk-cycle pulse on accepted 0->1 transition.
REQ-008 SHALL have port btn_release, output, 1 bit: single-clk-cycle pulse on accepted 1->0 transition.

Function
REQ-009 SHALL synchronise clk_div through two clk flip-flops (clk_div_s).
REQ-010 SHALL synchronise btn through two clk flip-flops (btn_s).
REQ-011 SHALL generate sample_tick, high for exactly one clk cycle when clk_div_s is 1 and its previous registered value is 0; no other event advances the debouncer.
REQ-012 SHALL implement a 4-state FSM: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW, plus a 4-bit sample counter cnt.
REQ-013 IDLE_LOW: on sample_tick with btn_s=1 -> CHECK_HIGH, cnt=1; otherwise hold, cnt=0.
REQ-014 CHECK_HIGH: on sample_tick with btn_s=0 -> IDLE_LOW, cnt=0.
REQ-015 CHECK_HIGH: on sample_tick with btn_s=1 and cnt=STABLE_COUNT-1 -> IDLE_HIGH, cnt=0; otherwise with btn_s=1, cnt increments.
REQ-016 IDLE_HIGH / CHECK_LOW SHALL mirror REQ-013..015 with btn_s polarity inverted, ending in IDLE_LOW.
REQ-017 Without sample_tick, FSM and cnt SHALL hold regardless of btn_s.
REQ-018 btn_level SHALL be a register: 1 in IDLE_HIGH and CHECK_LOW, 0 in IDLE_LOW and CHECK_HIGH; it updates on the same clk edge as the state transition.
REQ-019 btn_press SHALL be registered and high for exactly the one clk cycle following the CHECK_HIGH->IDLE_HIGH edge; btn_release likewise for CHECK_LOW->IDLE_LOW.
REQ-020 btn_press and btn_release SHALL never be high together; both SHALL be 0 in all other cycles.
REQ-021 Acceptance latency SHALL be STABLE_COUNT sample_ticks after btn_s first differs from btn_level, plus 2 clk cycles of btn synchronisation.
REQ-022 A contrary btn_s value at any sample_tick during CHECK_* SHALL abort the check with no change to btn_level and no pulse.
REQ-023 If clk_div stops toggling, outputs SHALL hold their current values indefinitely.
REQ-024 cnt SHALL never exceed STABLE_COUNT-1 and SHALL not wrap.

Reset
REQ-025 While clr=0 the block SHALL immediately, independent of clk, force state=IDLE_LOW, cnt=0, all synchroniser and edge-detect flops 0, btn_level=0, btn_press=0, btn_release=0.
REQ-026 Reset asserted mid-check or during a pulse SHALL abort it; no pulse SHALL appear after clr returns to 1.
REQ-027 After clr deassertion, a btn held at 1 SHALL be accepted as a normal press per REQ-013..019.

Verification
REQ-028 Clean press: STABLE_COUNT=4, clk_div toggles every 8 clk, btn 0->1 held -> btn_level=1 and one btn_press pulse after the 4th sample_tick; btn_release stays 0.
REQ-029 Bounce: btn toggles 1,0,1 across 3 successive sample_ticks, then holds 1 -> no output change until 4 consecutive 1 samples, then exactly one btn_press.
REQ-030 Release: from btn_level=1, btn 1->0 held -> btn_level=0 after 4 sample_ticks, exactly one btn_release pulse, no btn_press.
REQ-031 Short glitch: btn high for less than one clk_div period, between sample_ticks -> no state change, all outputs remain 0.
REQ-032 Reset mid-check: btn=1, clr pulled 0 after 2 sample_ticks -> outputs 0 immediately and asynchronously; after clr=1, 4 more high samples -> single btn_press.
REQ-033 Stopped clk_div: clk_div held at 0, btn toggles freely for 1000 clk -> btn_level, btn_press, btn_release unchanged.
